// File: rtl/avalon_mm_resp_pkg.sv
// rtl/avalon_mm_resp_pkg.sv - shared FSM state type and read-latency limits for the AMM responder
package avalon_mm_resp_pkg;

  typedef enum logic {INIT_S, READY_S} state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;

endpackage

// File: rtl/amm_if.sv
// rtl/amm_if.sv - Avalon-MM bus bundle; byteenable present only with AMM_RESP_BYTEEN_EN
interface amm_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
`ifdef AMM_RESP_BYTEEN_EN
  logic [DATA_W/8-1:0] byteenable;
`endif
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport responder (
`ifdef AMM_RESP_BYTEEN_EN
    input  byteenable,
`endif
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/amm_resp_rd_pipe.sv
// rtl/amm_resp_rd_pipe.sv - fixed-depth valid/data delay line for read responses
module amm_resp_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    assign vld_o  = vld_i;
    assign data_o = data_i;
  end else begin : g_dly
    logic [DEPTH-1:0]  vld_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    // Data stages only load behind a valid, so the output word holds between responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        vld_q[0] <= vld_i;
        if (vld_i) data_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];
  end

endmodule

// File: rtl/avalon_mm_mem_responder.sv
// rtl/avalon_mm_mem_responder.sv - Avalon-MM scratch RAM responder with post-reset clear
// Optional per-lane writes: AMM_RESP_BYTEEN_EN
module avalon_mm_mem_responder
  import avalon_mm_resp_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  amm_if.responder amm_i,
  output logic     err_o
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("avalon_mm_mem_responder: RD_LAT outside supported range");
  end
`ifdef AMM_RESP_BYTEEN_EN
  if (DATA_W % 8 != 0) begin : g_width_chk
    $error("avalon_mm_mem_responder: DATA_W must be a multiple of 8 with byte enables");
  end
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              err_q, err_d;
  logic              rd_vld_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic both_req, rd_acc, wr_acc;

  assign both_req          = amm_i.read & amm_i.write;
  assign amm_i.waitrequest = (state_q != READY_S) | both_req;
  assign rd_acc            = amm_i.read  & ~amm_i.waitrequest;
  assign wr_acc            = amm_i.write & ~amm_i.waitrequest;
  assign err_o             = err_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    err_d      = err_q | both_req;
    if (state_q == INIT_S) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) state_d = READY_S;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT_S;
      clr_addr_q <= '0;
      err_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      err_q      <= err_d;
      rd_vld_q   <= rd_acc;
      if (rd_acc) rd_data_q <= mem[amm_i.address];
    end
  end

  // Storage has no reset; the INIT_S sweep is what clears it after every reset.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT_S) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_acc) begin
`ifdef AMM_RESP_BYTEEN_EN
      for (int i = 0; i < DATA_W/8; i++)
        if (amm_i.byteenable[i]) mem[amm_i.address][8*i +: 8] <= amm_i.writedata[8*i +: 8];
`else
      mem[amm_i.address] <= amm_i.writedata;
`endif
    end
  end

  amm_resp_rd_pipe #(
    .DATA_W(DATA_W),
    .DEPTH (RD_LAT - 1)
  ) u_rd_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vld_i (rd_vld_q),
    .data_i(rd_data_q),
    .vld_o (amm_i.readdatavalid),
    .data_o(amm_i.readdata)
  );

endmodule

// File: tb/tb_avalon_mm_mem_responder.sv
// tb/tb_avalon_mm_mem_responder.sv - self-checking bench for avalon_mm_mem_responder
module tb_avalon_mm_mem_responder;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;
  always #5 clk = ~clk;

  amm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  avalon_mm_mem_responder #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .amm_i(bus),
    .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: memory image, init countdown, sticky error and pending responses.
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] m_mem [DEPTH];
  int          m_init   = 0;
  bit          m_err    = 1'b0;
  rsp_t        m_q[$];
  bit          exp_vld  = 1'b0;
  logic [31:0] exp_data = '0;
  int          cyc      = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_init   = 0;
      m_err    = 1'b0;
      m_q.delete();
      exp_vld  = 1'b0;
      exp_data = '0;
    end else begin
      cyc++;
      if (m_init < DEPTH) begin
        m_mem[m_init] = '0;
        m_init++;
      end else if (bus.read && bus.write) begin
        m_err = 1'b1;
      end else if (bus.write) begin
`ifdef AMM_RESP_BYTEEN_EN
        for (int b = 0; b < 4; b++)
          if (bus.byteenable[b]) m_mem[bus.address][8*b +: 8] = bus.writedata[8*b +: 8];
`else
        m_mem[bus.address] = bus.writedata;
`endif
      end else if (bus.read) begin
        m_q.push_back('{due: cyc + RD_LAT - 1, data: m_mem[bus.address]});
      end
      exp_vld = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        exp_vld  = 1'b1;
        exp_data = m_q[0].data;
        void'(m_q.pop_front());
      end
    end
  end

  logic [31:0] got_d[$];
  int          got_c[$];

  always @(negedge clk) begin
    logic exp_wait;
    exp_wait = (rst || m_init < DEPTH) ? 1'b1 : (bus.read & bus.write);
    chk("waitrequest", bus.waitrequest, exp_wait);
    chk("readdatavalid", bus.readdatavalid, exp_vld);
    chk("readdata", bus.readdata, exp_data);
    chk("err_o", err, m_err);
    if (bus.readdatavalid) begin
      got_d.push_back(bus.readdata);
      got_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.read      = 1'b0;
    bus.write     = 1'b1;
    bus.address   = a;
    bus.writedata = d;
`ifdef AMM_RESP_BYTEEN_EN
    bus.byteenable = be;
`else
    if (be == 4'h0) bus.writedata = d;
`endif
    step();
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.read    = 1'b1;
    bus.address = a;
    step();
    bus.read = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 20 && got_d.size() < n; i++) step();
    chk("rsp_count", got_d.size(), n);
  endtask

  task automatic count_init(input string name);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.waitrequest) n++;
      else break;
    end
    chk(name, n, 16);
    step();
  endtask

  initial begin
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
`ifdef AMM_RESP_BYTEEN_EN
    bus.byteenable = 4'hF;
`endif
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_waitrequest", bus.waitrequest, 1);
    chk("rst_readdatavalid", bus.readdatavalid, 0);
    chk("rst_readdata", bus.readdata, 0);
    chk("rst_err", err, 0);
    step();
    rst = 1'b0;

    // 1: 16-cycle clear, then every word reads back zero
    count_init("init_wait_cycles");
    got_d.delete();
    for (int i = 0; i < DEPTH; i++) rd(4'(i));
    wait_rsp(16);
    for (int i = 0; i < DEPTH && i < got_d.size(); i++) chk("clear_read", got_d[i], 32'h0);

    // 2: write then immediate read, latency 2
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    bus.read    = 1'b1;
    bus.address = 4'd3;
    @(negedge clk);
    chk("lat_cycle0_rdv", bus.readdatavalid, 0);
    step();
    bus.read = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_rdv", bus.readdatavalid, 0);
    step();
    @(negedge clk);
    chk("lat_cycle2_rdv", bus.readdatavalid, 1);
    chk("lat_cycle2_data", bus.readdata, 32'hDEADBEEF);
    step();

    // 3: back-to-back reads return in order on consecutive cycles
    for (int i = 0; i < 4; i++) wr(4'(i), 32'hA0 + i, 4'hF);
    got_d.delete();
    got_c.delete();
    for (int i = 0; i < 4; i++) rd(4'(i));
    wait_rsp(4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      chk("burst_data", got_d[i], 32'hA0 + i);
      chk("burst_spacing", got_c[i] - got_c[0], i);
    end

    // 4: read and write together are refused and flag a sticky error
    wr(4'd5, 32'h55, 4'hF);
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    bus.address   = 4'd5;
    bus.writedata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rw_waitrequest", bus.waitrequest, 1);
    step();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    @(negedge clk);
    chk("rw_err_set", err, 1);
    repeat (5) step();
    chk("rw_err_sticky", err, 1);
    got_d.delete();
    rd(4'd5);
    wait_rsp(1);
    if (got_d.size() > 0) chk("rw_mem_kept", got_d[0], 32'h55);

    // 5: reset right after a read is accepted swallows the response
    got_d.delete();
    bus.read    = 1'b1;
    bus.address = 4'd5;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    rst      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_rdv", bus.readdatavalid, 0);
      chk("midrst_waitrequest", bus.waitrequest, 1);
    end
    step();
    rst = 1'b0;
    count_init("reinit_wait_cycles");
    chk("midrst_no_rsp", got_d.size(), 0);
    chk("midrst_err_cleared", err, 0);
    rd(4'd5);
    wait_rsp(1);
    if (got_d.size() > 0) chk("midrst_mem_cleared", got_d[0], 32'h0);

`ifdef AMM_RESP_BYTEEN_EN
    // 6: lane-masked writes
    wr(4'd7, 32'h11223344, 4'hF);
    wr(4'd7, 32'h0000AB00, 4'b0010);
    wr(4'd7, 32'hFFFFFFFF, 4'b0000);
    got_d.delete();
    rd(4'd7);
    wait_rsp(1);
    if (got_d.size() > 0) chk("byteen_merge", got_d[0], 32'h1122AB44);
`endif

    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
